// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Producer end of the 8-bit instruction interface. Holds the fetch PC,
//   fetches instruction bytes from program memory over a req/ack handshake
//   into a 2-entry prefetch buffer and presents the head entry to the control
//   unit. A redirect flushes the buffer and discards any in-flight fetch.
//
// Ports
//   clk          in   rising-edge clock
//   rstN         in   asynchronous active-low reset
//   memReq       out  fetch request, held with memAddr stable until memAck
//   memAddr      out  fetch address
//   memAck       in   memData valid, completes the current request
//   memData      in   fetched instruction byte
//   inst         out  head instruction (NOP_INST when buffer empty)
//   instAddr     out  address of head instruction (0 when empty)
//   instValid    out  head entry present
//   instTake     in   control unit consumes the head this cycle
//   redirect     in   taken jump/branch this cycle
//   redirectAddr in   new PC when redirect is high
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  NOP_INST = 8'h00
) (
    input  logic              clk,
    input  logic              rstN,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [7:0]        memData,
    output logic [7:0]        inst,
    output logic [ADDR_W-1:0] instAddr,
    output logic              instValid,
    input  logic              instTake,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectAddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              memReq_q, memReq_d;
    logic [1:0]        count_q, count_d;
    logic [7:0]        bufData_q [2];
    logic [7:0]        bufData_d [2];
    logic [ADDR_W-1:0] bufAddr_q [2];
    logic [ADDR_W-1:0] bufAddr_d [2];

    logic              pop;
    logic [1:0]        cntAfterPop;

    assign pop         = instTake && (count_q != 2'd0);
    assign cntAfterPop = count_q - {1'b0, pop};

    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        count_d   = count_q;
        bufData_d = bufData_q;
        bufAddr_d = bufAddr_q;

        if (redirect) begin
            // Flush wins over everything; a same-cycle take is the branch itself.
            count_d   = 2'd0;
            fetchPc_d = redirectAddr;
            case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = memAck ? REQ : DROP;
                DROP:    state_d = memAck ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            // Buffer is a 2-deep shift register; entry 0 is always the head.
            if (pop) begin
                bufData_d[0] = bufData_q[1];
                bufAddr_d[0] = bufAddr_q[1];
            end
            count_d = cntAfterPop;
            case (state_q)
                IDLE: begin
                    if (cntAfterPop < 2'd2) state_d = REQ;
                end
                REQ: begin
                    // In REQ count <= 1, so the tail slot index fits in one bit.
                    if (memAck) begin
                        bufData_d[cntAfterPop[0]] = memData;
                        bufAddr_d[cntAfterPop[0]] = fetchPc_q;
                        count_d   = cntAfterPop + 2'd1;
                        fetchPc_d = fetchPc_q + 1'b1;
                        state_d   = (cntAfterPop + 2'd1 < 2'd2) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (memAck) state_d = REQ;
                end
                default: state_d = IDLE;
            endcase
        end

        // A fresh request always targets the next PC; DROP keeps the old address.
        memAddr_d = (state_d == REQ) ? fetchPc_d : memAddr_q;
        memReq_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            fetchPc_q <= '0;
            memAddr_q <= '0;
            memReq_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            memAddr_q <= memAddr_d;
            memReq_q  <= memReq_d;
            count_q   <= count_d;
        end
    end

    // Buffer payload needs no reset: it is only visible when count_q is non-zero.
    always_ff @(posedge clk) begin
        bufData_q <= bufData_d;
        bufAddr_q <= bufAddr_d;
    end

    assign memReq    = memReq_q;
    assign memAddr   = memAddr_q;
    assign instValid = (count_q != 2'd0);
    assign inst      = instValid ? bufData_q[0] : NOP_INST;
    assign instAddr  = instValid ? bufAddr_q[0] : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rstN;
    logic       memReq;
    logic [7:0] memAddr;
    logic       memAck;
    logic [7:0] memData;
    logic [7:0] inst;
    logic [7:0] instAddr;
    logic       instValid;
    logic       instTake;
    logic       redirect;
    logic [7:0] redirectAddr;

    int n_checks = 0;
    int n_fail   = 0;

    // responder controls
    int         ack_delay = 0;
    int         ack_cnt   = 0;
    logic       hold_en   = 1'b0;
    logic [7:0] hold_addr = 8'h00;

    logic [7:0] exp_q[$];

    instruction_fetch #(.ADDR_W(8), .NOP_INST(8'h00)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .memReq       (memReq),
        .memAddr      (memAddr),
        .memAck       (memAck),
        .memData      (memData),
        .inst         (inst),
        .instAddr     (instAddr),
        .instValid    (instValid),
        .instTake     (instTake),
        .redirect     (redirect),
        .redirectAddr (redirectAddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic take);
        rstN         = 1'b0;
        redirect     = 1'b0;
        redirectAddr = 8'h00;
        instTake     = take;
        hold_en      = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        ack_cnt = 0;
        rstN    = 1'b1;
    endtask

    task automatic push_range(input logic [7:0] start, input int n);
        logic [7:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 8'h01;
        end
    endtask

    // Waits until the scoreboard has been consumed, then stops taking.
    task automatic wait_drain(input string tag, input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound) begin
            cyc();
            cycles++;
            if (exp_q.size() == 0) break;
        end
        instTake = 1'b0;
        chk(tag, exp_q.size(), 0);
    endtask

    // Memory model: mem[a] = a + 8'h10, ack after ack_delay wait cycles.
    initial begin
        int wc;
        wc      = 0;
        memAck  = 1'b0;
        memData = 8'h00;
        forever begin
            @(negedge clk);
            if (rstN && memReq && !(hold_en && memAddr == hold_addr)) begin
                if (wc >= ack_delay) begin
                    memAck  = 1'b1;
                    memData = memAddr + 8'h10;
                    wc      = 0;
                    ack_cnt++;
                end else begin
                    memAck = 1'b0;
                    wc++;
                end
            end else begin
                memAck = 1'b0;
                wc     = 0;
            end
        end
    end

    // Scoreboard consumer: every instruction the control unit takes must match.
    initial begin
        logic [7:0] a;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (rstN && instValid && instTake && !redirect) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    a = exp_q.pop_front();
                    d = a + 8'h10;
                    chk("sb_addr", instAddr, a);
                    chk("sb_inst", inst, d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;

        // Reset state
        rstN         = 1'b0;
        redirect     = 1'b0;
        redirectAddr = 8'h00;
        instTake     = 1'b0;
        @(negedge clk);
        chk("rst_memReq", memReq, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_inst", inst, 8'h00);
        chk("rst_instAddr", instAddr, 0);
        chk("rst_instValid", instValid, 0);

        // 1: zero-wait streaming, one instruction per cycle
        ack_delay = 0;
        do_reset(1'b1);
        push_range(8'h00, 8);
        @(negedge clk);
        chk("t1_req_before_edge", memReq, 0);
        @(negedge clk);
        chk("t1_first_req", memReq, 1);
        chk("t1_first_addr", memAddr, 0);
        wait_drain("t1_drain", 30, n);
        chk("t1_rate", n, 9);

        // 2: no take -> buffer fills with two entries and fetching stops
        do_reset(1'b0);
        push_range(8'h00, 3);
        repeat (6) cyc();
        @(negedge clk);
        chk("t2_memReq_idle", memReq, 0);
        chk("t2_valid", instValid, 1);
        chk("t2_inst_held", inst, 8'h10);
        chk("t2_addr_held", instAddr, 0);
        cyc();
        chk("t2_acks", ack_cnt, 2);
        instTake = 1'b1;
        cyc();
        instTake = 1'b0;
        @(negedge clk);
        chk("t2_inst_next", inst, 8'h11);
        chk("t2_addr_next", instAddr, 1);
        chk("t2_refetch_req", memReq, 1);
        chk("t2_refetch_addr", memAddr, 2);
        repeat (3) cyc();
        chk("t2_acks_after", ack_cnt, 3);
        @(negedge clk);
        chk("t2_memReq_low", memReq, 0);

        // 3: slow memory, request held stable
        ack_delay = 3;
        do_reset(1'b1);
        push_range(8'h00, 2);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_req_held", memReq, 1);
            chk("t3_addr_stable", memAddr, 0);
            chk("t3_valid_low", instValid, 0);
            chk("t3_inst_nop", inst, 8'h00);
        end
        wait_drain("t3_drain", 40, n);

        // 4: redirect while a request is pending -> DROP, data discarded
        ack_delay = 0;
        do_reset(1'b1);
        hold_en   = 1'b1;
        hold_addr = 8'h05;
        push_range(8'h00, 5);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (memReq && memAddr == 8'h05) found = 1;
        end
        chk("t4_reach_addr5", found, 1);
        cyc();
        chk("t4_pre_flush", exp_q.size(), 0);
        redirect     = 1'b1;
        redirectAddr = 8'h40;
        exp_q.delete();
        push_range(8'h40, 4);
        cyc();
        redirect = 1'b0;
        hold_en  = 1'b0;
        @(negedge clk);
        chk("t4_drop_req", memReq, 1);
        chk("t4_drop_addr", memAddr, 8'h05);
        chk("t4_drop_empty", instValid, 0);
        @(negedge clk);
        chk("t4_new_req", memReq, 1);
        chk("t4_new_addr", memAddr, 8'h40);
        chk("t4_still_empty", instValid, 0);
        wait_drain("t4_drain", 30, n);

        // 5: redirect and memAck in the same cycle, with instTake
        do_reset(1'b1);
        push_range(8'h00, 4);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (memReq && memAddr == 8'h03) found = 1;
        end
        chk("t5_reach_addr3", found, 1);
        cyc();
        chk("t5_pending", exp_q.size(), 1);
        redirect     = 1'b1;
        redirectAddr = 8'h80;
        exp_q.delete();
        push_range(8'h80, 4);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("t5_new_req", memReq, 1);
        chk("t5_new_addr", memAddr, 8'h80);
        chk("t5_flushed", instValid, 0);
        wait_drain("t5_drain", 30, n);

        // 6: redirect from IDLE near the top of memory, PC wraps
        do_reset(1'b0);
        repeat (5) cyc();
        redirect     = 1'b1;
        redirectAddr = 8'hFE;
        instTake     = 1'b1;
        exp_q.delete();
        push_range(8'hFE, 4);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("t6_req", memReq, 1);
        chk("t6_addr_fe", memAddr, 8'hFE);
        wait_drain("t6_wrap_drain", 30, n);

        // reset in the middle of a held request
        hold_en      = 1'b1;
        hold_addr    = 8'h20;
        redirect     = 1'b1;
        redirectAddr = 8'h20;
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        chk("t6_hold_req", memReq, 1);
        chk("t6_hold_addr", memAddr, 8'h20);
        #1;
        rstN = 1'b0;
        #1;
        chk("t6_async_req", memReq, 0);
        chk("t6_async_addr", memAddr, 0);
        chk("t6_async_valid", instValid, 0);
        cyc();
        hold_en = 1'b0;
        exp_q.delete();
        rstN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_restart_req", memReq, 1);
        chk("t6_restart_addr", memAddr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
